// File: rtl/clock_divider_if.sv
// Control/status bundle for the programmable clock divider.
// The master side (controller) requests run/ratio changes; the slave side
// (divider) returns the divided clock, its tick and the ratio status pulses.
interface clock_divider_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] cur_div;

    modport master (
        output en, div_val, div_load,
        input  div_ack, div_err, clk_out, tick, cur_div
    );

    modport slave (
        input  en, div_val, div_load,
        output div_ack, div_err, clk_out, tick, cur_div
    );
endinterface

// File: rtl/clock_divider.sv
// Programmable integer clock divider feeding the clock buffer stage.
// clk_out is a register in the clk_in domain. Ratio changes take effect only
// at a period boundary and a disable lets the running period finish, so the
// buffer never sees a runt or glitch pulse.
module clock_divider #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic            clk_in,
    input  logic            rst,
    clock_divider_if.slave  bus
);

    // Reject an unusable reset ratio at elaboration time.
    generate
        if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** CNT_W) - 1) begin : g_bad_default
            $error("clock_divider: DEFAULT_DIV out of range 2..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend, pend_d;
    logic             pend_vld, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             boundary;   // last cycle of the current period
    logic             apply;      // pending ratio becomes active this edge
    logic [CNT_W-1:0] n_eff;      // ratio governing the next cycle
    logic [CNT_W-1:0] cnt_inc;    // counter value after this edge while counting
    logic             load_ok;
    logic             load_bad;

    // Decode ratio requests and the period boundary.
    always_comb begin
        load_ok  = bus.div_load && (bus.div_val >= CNT_W'(2));
        load_bad = bus.div_load && (bus.div_val <  CNT_W'(2));
        boundary = (state != IDLE) && (cnt == cur_div_q - 1'b1);
        // While idle there is no waveform to protect, so a pending ratio
        // can be taken immediately.
        apply    = pend_vld && ((state == IDLE) || boundary);
        n_eff    = apply ? pend : cur_div_q;
        cnt_inc  = boundary ? '0 : cnt + 1'b1;
    end

    // Next-state, counter, waveform and ratio bookkeeping.
    always_comb begin
        state_nxt  = state;
        cnt_d      = cnt;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        err_d      = load_bad;
        cur_div_d  = cur_div_q;
        pend_d     = pend;
        pend_vld_d = pend_vld;

        case (state)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (bus.en) begin
                    state_nxt = RUN;
                    clk_d     = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            RUN, STOP: begin
                cnt_d  = cnt_inc;
                // High for the first floor(N/2) counts of each period.
                clk_d  = cnt_inc < (n_eff >> 1);
                tick_d = (cnt_inc == '0);
                if (state == STOP && boundary && !bus.en) begin
                    // Disabled period has completed: park low.
                    state_nxt = IDLE;
                    cnt_d     = '0;
                    clk_d     = 1'b0;
                    tick_d    = 1'b0;
                end else begin
                    state_nxt = bus.en ? RUN : STOP;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_d     = '0;
                clk_d     = 1'b0;
            end
        endcase

        if (apply) begin
            cur_div_d  = pend;
            ack_d      = 1'b1;
            pend_vld_d = 1'b0;
        end

        // A load on the applying edge is only captured; it waits for the
        // next boundary.
        if (load_ok) begin
            pend_d     = bus.div_val;
            pend_vld_d = 1'b1;
        end
    end

    // State and datapath registers; reset abandons any period in progress.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_div_q <= DEF_DIV;
            pend      <= '0;
            pend_vld  <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_d;
            cur_div_q <= cur_div_d;
            pend      <= pend_d;
            pend_vld  <= pend_vld_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign bus.clk_out = clk_q;
    assign bus.tick    = tick_q;
    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
    assign bus.cur_div = cur_div_q;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: a period-queue model predicts every output each
// cycle, and directed scenarios add literal waveform/period expectations.
module tb_clock_divider;
    localparam int CNT_W = 8;
    localparam int DEF   = 2;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    clock_divider_if #(.CNT_W(CNT_W)) bus ();

    clock_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- model: one queue entry per clk_in cycle of a period
    bit [1:0] q[$];          // {tick, clk_out}
    int  m_cur  = DEF;
    int  m_pend = 0;
    bit  m_pv   = 0;
    bit  m_run  = 0;
    bit  m_stop = 0;
    bit  e_clk = 0, e_tick = 0, e_ack = 0, e_err = 0;

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            q.delete();
            m_cur = DEF; m_pv = 0; m_run = 0; m_stop = 0;
            e_clk = 0; e_tick = 0; e_ack = 0; e_err = 0;
        end else begin
            bit [1:0] ent;
            bit go;
            e_ack = 0;
            e_err = bus.div_load && (int'(bus.div_val) < 2);
            if (!m_run || q.size() == 0) begin
                if (m_pv) begin m_cur = m_pend; m_pv = 0; e_ack = 1; end
                go = m_run ? !(m_stop && !bus.en) : bus.en;
                if (go) begin
                    for (int i = 0; i < m_cur; i++)
                        q.push_back({(i == 0), (i < m_cur / 2)});
                end
                m_run = go;
            end
            if (m_run) begin
                ent    = q.pop_front();
                e_tick = ent[1];
                e_clk  = ent[0];
                m_stop = !bus.en;
            end else begin
                e_tick = 0; e_clk = 0; m_stop = 0;
            end
            if (bus.div_load && int'(bus.div_val) >= 2) begin
                m_pend = int'(bus.div_val);
                m_pv   = 1;
            end
        end
    end

    // Compare every cycle away from the active edge.
    always @(negedge clk_in) begin
        check("clk_out", bus.clk_out, e_clk);
        check("tick",    bus.tick,    e_tick);
        check("div_ack", bus.div_ack, e_ack);
        check("div_err", bus.div_err, e_err);
        check("cur_div", bus.cur_div, m_cur);
    end

    // ---------------- waveform measurement
    realtime t_rise = 0, per = 0, hi = 0;
    int n_rise = 0;
    always @(posedge bus.clk_out) begin
        if (t_rise > 0) per = $realtime - t_rise;
        t_rise = $realtime;
        n_rise++;
    end
    always @(negedge bus.clk_out) hi = $realtime - t_rise;

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic load(input int v);
        bus.div_val  = v[CNT_W-1:0];
        bus.div_load = 1'b1;
        step(1);
        bus.div_load = 1'b0;
    endtask

    task automatic wait_tick(input string nm);
        bit ok = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk_in);
            if (bus.tick) begin ok = 1; break; end
        end
        if (!ok) begin
            chk_cnt++;
            $display("FAIL %s: tick not seen within 700 cycles", nm);
        end
    endtask

    task automatic measure(input string nm, input int n);
        repeat (3) wait_tick(nm);
        check({nm, " period"}, int'(per), n * 10);
        check({nm, " high"},   int'(hi),  (n / 2) * 10);
    endtask

    initial begin
        int r0;
        bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
        rst = 1'b1;
        step(2);
        check("reset clk_out", bus.clk_out, 0);
        check("reset cur_div", bus.cur_div, DEF);
        rst = 1'b0;
        step(2);

        // N=2, first rise one edge after en
        bus.en = 1'b1;
        step(1);
        check("first rise", bus.clk_out, 1);
        check("first tick", bus.tick, 1);
        step(1);
        check("n2 low", bus.clk_out, 0);
        measure("n2", 2);
        load(3);   measure("n3", 3);
        load(255); measure("n255", 255);

        // N=5 then a mid-period change to 8
        load(5); measure("n5", 5);
        wait_tick("t2");
        step(2);
        load(8);
        check("t2 cur held", bus.cur_div, 5);
        step(1);
        check("t2 no early ack", bus.div_ack, 0);
        step(1);
        check("t2 ack", bus.div_ack, 1);
        check("t2 cur new", bus.cur_div, 8);
        check("t2 rise", bus.clk_out, 1);
        measure("n8", 8);

        // Disable at cnt=1 with N=6, then re-enable during STOP
        load(6); measure("n6", 6);
        wait_tick("t3");
        step(1);
        bus.en = 1'b0;
        step(1);
        check("t3 finish high", bus.clk_out, 1);
        step(3);
        check("t3 finish low", bus.clk_out, 0);
        r0 = n_rise;
        step(30);
        check("t3 no rise", n_rise, r0);
        check("t3 idle low", bus.clk_out, 0);
        bus.en = 1'b1;
        wait_tick("t3 restart");
        step(1);
        bus.en = 1'b0;
        step(1);
        bus.en = 1'b1;
        measure("t3 cont", 6);

        // Rejected ratios
        step(2);
        bus.div_val = '0; bus.div_load = 1'b1;
        step(1);
        bus.div_load = 1'b0;
        check("err0 pulse", bus.div_err, 1);
        check("err0 cur", bus.cur_div, 6);
        step(1);
        check("err0 single", bus.div_err, 0);
        load(1);
        check("err1 pulse", bus.div_err, 1);
        measure("t4", 6);

        // Reset in the high phase with N=10
        load(10); measure("n10", 10);
        wait_tick("t5");
        #2 rst = 1'b1;
        #1;
        check("rst clk_out", bus.clk_out, 0);
        check("rst tick", bus.tick, 0);
        check("rst cur_div", bus.cur_div, DEF);
        @(negedge clk_in);
        rst = 1'b0;
        step(4);
        check("post rst cur", bus.cur_div, DEF);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
